// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
// Counter encodings, table sizing and PC-select codes.
package branch_predictor_pkg;

    localparam int BP_ENTRIES = 16;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_e;

    localparam bp_ctr_e BP_INIT_CTR = BP_WT;
    localparam bp_ctr_e BP_RST_CTR  = BP_WNT;

    typedef enum logic [1:0] {
        PCMUX_SEQ    = 2'b00,
        PCMUX_PRED   = 2'b01,
        PCMUX_BRANCH = 2'b10,
        PCMUX_CORR   = 2'b11
    } pcmux_e;

    // A redirect from EX always overrides the fetch-side prediction.
    function automatic pcmux_e pcmux_sel(
        input logic pred_taken,
        input logic mispredict,
        input logic ex_taken
    );
        pcmux_sel = PCMUX_SEQ;
        if (mispredict)
            pcmux_sel = ex_taken ? PCMUX_BRANCH : PCMUX_CORR;
        else if (pred_taken)
            pcmux_sel = PCMUX_PRED;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, EX resolve and redirect bundle of the branch predictor.
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        flush_btb;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispred_count;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_taken, ex_target,
        output ex_pred_taken, ex_pred_target, flush_btb,
        input  pred_taken, pred_target, mispredict, redirect_pc,
        input  branch_count, mispred_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_taken, ex_target,
        input  ex_pred_taken, ex_pred_target, flush_btb,
        output pred_taken, pred_target, mispredict, redirect_pc,
        output branch_count, mispred_count
    );
endinterface

// File: rtl/branch_predictor_btb_table.sv
// BTB storage: valid/tag/target/counter per entry, async lookup read,
// one write port with its own read-back, and a bulk valid clear.
module btb_table
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES,
    parameter int INDEX_W = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - INDEX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [29:0]        rd_target_o,
    output bp_ctr_e            rd_ctr_o,
    input  logic [INDEX_W-1:0] up_idx_i,
    output logic               up_valid_o,
    output logic [TAG_W-1:0]   up_tag_o,
    output logic [29:0]        up_target_o,
    output bp_ctr_e            up_ctr_o,
    input  logic               wr_en_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [29:0]        wr_target_i,
    input  bp_ctr_e            wr_ctr_i,
    input  logic               clr_i
);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [29:0]        tgt_q [ENTRIES];
    bp_ctr_e            ctr_q [ENTRIES];

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = tgt_q[rd_idx_i];
    assign rd_ctr_o    = ctr_q[rd_idx_i];

    assign up_valid_o  = valid_q[up_idx_i];
    assign up_tag_o    = tag_q[up_idx_i];
    assign up_target_o = tgt_q[up_idx_i];
    assign up_ctr_o    = ctr_q[up_idx_i];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= BP_RST_CTR;
            end
        end else begin
            if (clr_i)
                valid_q <= '0;
            else if (wr_en_i)
                valid_q[up_idx_i] <= 1'b1;
            if (wr_en_i) begin
                tag_q[up_idx_i] <= wr_tag_i;
                tgt_q[up_idx_i] <= wr_target_i;
                ctr_q[up_idx_i] <= wr_ctr_i;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side BTB with 2-bit direction counters, EX-side mispredict
// detection, table update and performance counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);

    localparam int INDEX_W = $clog2(ENTRIES);
    localparam int TAG_W   = 30 - INDEX_W;

    function automatic bp_ctr_e ctr_next(
        input bp_ctr_e c,
        input logic    taken
    );
        ctr_next = c;
        if (taken && c != BP_ST)
            ctr_next = bp_ctr_e'(c + 2'd1);
        else if (!taken && c != BP_SNT)
            ctr_next = bp_ctr_e'(c - 2'd1);
    endfunction

    logic [INDEX_W-1:0] lk_idx, ex_idx;
    logic [TAG_W-1:0]   lk_tag, ex_tag, rd_tag, up_tag;
    logic               rd_valid, up_valid;
    logic [29:0]        rd_tgt, up_tgt, wr_tgt;
    bp_ctr_e            rd_ctr, up_ctr, wr_ctr;
    logic               lk_hit, ex_hit, pt, mp, wr_en;
    logic [31:0]        branch_cnt_q, branch_cnt_d;
    logic [31:0]        mispred_cnt_q, mispred_cnt_d;

    assign lk_idx = bp.if_pc[INDEX_W+1:2];
    assign lk_tag = bp.if_pc[31:INDEX_W+2];
    assign ex_idx = bp.ex_pc[INDEX_W+1:2];
    assign ex_tag = bp.ex_pc[31:INDEX_W+2];

    btb_table #(
        .ENTRIES (ENTRIES),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (lk_idx),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_target_o (rd_tgt),
        .rd_ctr_o    (rd_ctr),
        .up_idx_i    (ex_idx),
        .up_valid_o  (up_valid),
        .up_tag_o    (up_tag),
        .up_target_o (up_tgt),
        .up_ctr_o    (up_ctr),
        .wr_en_i     (wr_en),
        .wr_tag_i    (ex_tag),
        .wr_target_i (wr_tgt),
        .wr_ctr_i    (wr_ctr),
        .clr_i       (bp.flush_btb)
    );

    assign lk_hit = rd_valid && (rd_tag == lk_tag);
    assign pt     = lk_hit && (rd_ctr inside {BP_WT, BP_ST});

    assign bp.pred_taken  = pt;
    assign bp.pred_target = pt ? {rd_tgt, 2'b00}
                               : bp.if_pc + 32'd4;

    assign mp = bp.ex_valid &&
                ((bp.ex_pred_taken != bp.ex_taken) ||
                 (bp.ex_taken &&
                  bp.ex_pred_target != bp.ex_target));

    assign bp.mispredict  = mp;
    assign bp.redirect_pc = bp.ex_taken ? bp.ex_target
                                        : bp.ex_pc + 32'd4;

    // Flush wins over a same-cycle write so nothing is allocated.
    assign ex_hit = up_valid && (up_tag == ex_tag);
    assign wr_en  = bp.ex_valid && !bp.flush_btb &&
                    (ex_hit || bp.ex_taken);
    assign wr_ctr = ex_hit ? ctr_next(up_ctr, bp.ex_taken)
                           : BP_INIT_CTR;
    assign wr_tgt = bp.ex_taken ? bp.ex_target[31:2] : up_tgt;

    always_comb begin
        branch_cnt_d  = branch_cnt_q + {31'd0, bp.ex_valid};
        mispred_cnt_d = mispred_cnt_q + {31'd0, mp};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bp.branch_count  = branch_cnt_q;
    assign bp.mispred_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed tables plus a
// randomized run against a behavioural BTB model.
module tb_branch_predictor;

    logic clk;
    logic rst;

    branch_predictor_if bp_if ();

    branch_predictor #(.ENTRIES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic        mp;
        logic [31:0] rpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic [31:0] xpc;
        logic        t;
        logic [31:0] xt;
        logic        pt;
        logic [31:0] ptg;
        logic        fl;
        exp_t        e;
    } row_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    logic [1:0]  m_ctr   [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t mk(
        input logic [31:0] pc, input logic v,
        input logic [31:0] xpc, input logic t,
        input logic [31:0] xt, input logic pt,
        input logic [31:0] ptg, input logic fl,
        input logic ept, input logic [31:0] eptg,
        input logic emp, input logic [31:0] erpc,
        input logic [31:0] ebc, input logic [31:0] emc
    );
        row_t r;
        r.pc = pc; r.v = v; r.xpc = xpc; r.t = t;
        r.xt = xt; r.pt = pt; r.ptg = ptg; r.fl = fl;
        r.e.pt = ept; r.e.ptgt = eptg; r.e.mp = emp;
        r.e.rpc = erpc; r.e.bc = ebc; r.e.mc = emc;
        return r;
    endfunction

    function automatic row_t idle(
        input logic [31:0] pc, input logic ept,
        input logic [31:0] eptg,
        input logic [31:0] ebc, input logic [31:0] emc
    );
        return mk(pc, 0, 0, 0, 0, 0, 0, 0,
                  ept, eptg, 0, 32'h4, ebc, emc);
    endfunction

    task automatic drive(
        input logic [31:0] pc, input logic v,
        input logic [31:0] xpc, input logic t,
        input logic [31:0] xt, input logic pt,
        input logic [31:0] ptg, input logic fl
    );
        bp_if.if_pc          = pc;
        bp_if.ex_valid       = v;
        bp_if.ex_pc          = xpc;
        bp_if.ex_taken       = t;
        bp_if.ex_target      = xt;
        bp_if.ex_pred_taken  = pt;
        bp_if.ex_pred_target = ptg;
        bp_if.flush_btb      = fl;
    endtask

    task automatic apply(input row_t r);
        drive(r.pc, r.v, r.xpc, r.t, r.xt, r.pt, r.ptg, r.fl);
        exp_q.push_back(r.e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        drive(32'h100, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            e.pt = 0; e.ptgt = 32'h104; e.mp = 0;
            e.rpc = 32'h4; e.bc = 0; e.mc = 0;
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            checks += 4;
            if (bp_if.pred_taken !== e.pt) begin
                errors++;
                $display("FAIL reset[%0d] pred_taken got %b want %b",
                         k, bp_if.pred_taken, e.pt);
            end
            if (bp_if.pred_target !== e.ptgt) begin
                errors++;
                $display("FAIL reset[%0d] pred_target got %h want %h",
                         k, bp_if.pred_target, e.ptgt);
            end
            if (bp_if.branch_count !== e.bc) begin
                errors++;
                $display("FAIL reset[%0d] branch_count got %0d want %0d",
                         k, bp_if.branch_count, e.bc);
            end
            if (bp_if.mispred_count !== e.mc) begin
                errors++;
                $display("FAIL reset[%0d] mispred_count got %0d want %0d",
                         k, bp_if.mispred_count, e.mc);
            end
            tick();
            rst = 1'b0;
        end
    endtask

    task automatic test_allocate();
        row_t r[$];
        exp_t e;
        r.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0,
                       0, 32'h104, 1, 32'h200, 0, 0));
        r.push_back(idle(32'h100, 1, 32'h200, 1, 1));
        r.push_back(idle(32'h140, 0, 32'h144, 1, 1));
        r.push_back(mk(32'h140, 1, 32'h140, 1, 32'h300, 0, 32'h144, 0,
                       0, 32'h144, 1, 32'h300, 1, 1));
        r.push_back(idle(32'h140, 1, 32'h300, 2, 2));
        r.push_back(idle(32'h100, 0, 32'h104, 2, 2));
        foreach (r[i]) begin
            apply(r[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks += 6;
            if (bp_if.pred_taken !== e.pt) begin
                errors++;
                $display("FAIL alloc[%0d] pred_taken got %b want %b",
                         i, bp_if.pred_taken, e.pt);
            end
            if (bp_if.pred_target !== e.ptgt) begin
                errors++;
                $display("FAIL alloc[%0d] pred_target got %h want %h",
                         i, bp_if.pred_target, e.ptgt);
            end
            if (bp_if.mispredict !== e.mp) begin
                errors++;
                $display("FAIL alloc[%0d] mispredict got %b want %b",
                         i, bp_if.mispredict, e.mp);
            end
            if (bp_if.redirect_pc !== e.rpc) begin
                errors++;
                $display("FAIL alloc[%0d] redirect_pc got %h want %h",
                         i, bp_if.redirect_pc, e.rpc);
            end
            if (bp_if.branch_count !== e.bc) begin
                errors++;
                $display("FAIL alloc[%0d] branch_count got %0d want %0d",
                         i, bp_if.branch_count, e.bc);
            end
            if (bp_if.mispred_count !== e.mc) begin
                errors++;
                $display("FAIL alloc[%0d] mispred_count got %0d want %0d",
                         i, bp_if.mispred_count, e.mc);
            end
            tick();
        end
    endtask

    task automatic test_hysteresis();
        row_t r[$];
        exp_t e;
        r.push_back(mk(32'h140, 1, 32'h140, 0, 32'h300, 1, 32'h300, 0,
                       1, 32'h300, 1, 32'h144, 2, 2));
        r.push_back(idle(32'h140, 0, 32'h144, 3, 3));
        r.push_back(mk(32'h140, 1, 32'h140, 1, 32'h300, 0, 32'h144, 0,
                       0, 32'h144, 1, 32'h300, 3, 3));
        r.push_back(mk(32'h140, 1, 32'h140, 1, 32'h300, 1, 32'h300, 0,
                       1, 32'h300, 0, 32'h300, 4, 4));
        r.push_back(mk(32'h140, 1, 32'h140, 1, 32'h300, 1, 32'h300, 0,
                       1, 32'h300, 0, 32'h300, 5, 4));
        r.push_back(mk(32'h140, 1, 32'h140, 0, 32'h300, 1, 32'h300, 0,
                       1, 32'h300, 1, 32'h144, 6, 4));
        r.push_back(idle(32'h140, 1, 32'h300, 7, 5));
        r.push_back(mk(32'h140, 1, 32'h140, 1, 32'h308, 1, 32'h300, 0,
                       1, 32'h300, 1, 32'h308, 7, 5));
        r.push_back(idle(32'h140, 1, 32'h308, 8, 6));
        r.push_back(mk(32'h140, 1, 32'h140, 0, 32'h308, 1, 32'h308, 0,
                       1, 32'h308, 1, 32'h144, 8, 6));
        r.push_back(mk(32'h140, 1, 32'h140, 0, 32'h308, 1, 32'h308, 0,
                       1, 32'h308, 1, 32'h144, 9, 7));
        r.push_back(mk(32'h140, 1, 32'h140, 0, 32'h308, 0, 32'h144, 0,
                       0, 32'h144, 0, 32'h144, 10, 8));
        r.push_back(mk(32'h140, 1, 32'h140, 0, 32'h308, 0, 32'h144, 0,
                       0, 32'h144, 0, 32'h144, 11, 8));
        r.push_back(mk(32'h140, 1, 32'h140, 1, 32'h308, 0, 32'h144, 0,
                       0, 32'h144, 1, 32'h308, 12, 8));
        r.push_back(idle(32'h140, 0, 32'h144, 13, 9));
        foreach (r[i]) begin
            apply(r[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks += 6;
            if (bp_if.pred_taken !== e.pt) begin
                errors++;
                $display("FAIL hyst[%0d] pred_taken got %b want %b",
                         i, bp_if.pred_taken, e.pt);
            end
            if (bp_if.pred_target !== e.ptgt) begin
                errors++;
                $display("FAIL hyst[%0d] pred_target got %h want %h",
                         i, bp_if.pred_target, e.ptgt);
            end
            if (bp_if.mispredict !== e.mp) begin
                errors++;
                $display("FAIL hyst[%0d] mispredict got %b want %b",
                         i, bp_if.mispredict, e.mp);
            end
            if (bp_if.redirect_pc !== e.rpc) begin
                errors++;
                $display("FAIL hyst[%0d] redirect_pc got %h want %h",
                         i, bp_if.redirect_pc, e.rpc);
            end
            if (bp_if.branch_count !== e.bc) begin
                errors++;
                $display("FAIL hyst[%0d] branch_count got %0d want %0d",
                         i, bp_if.branch_count, e.bc);
            end
            if (bp_if.mispred_count !== e.mc) begin
                errors++;
                $display("FAIL hyst[%0d] mispred_count got %0d want %0d",
                         i, bp_if.mispred_count, e.mc);
            end
            tick();
        end
    endtask

    task automatic test_same_cycle();
        row_t r[$];
        exp_t e;
        r.push_back(mk(32'h180, 1, 32'h180, 1, 32'h400, 0, 32'h184, 0,
                       0, 32'h184, 1, 32'h400, 13, 9));
        r.push_back(idle(32'h180, 1, 32'h400, 14, 10));
        r.push_back(mk(32'h180, 0, 32'h1c0, 1, 32'h500, 0, 32'h0, 0,
                       1, 32'h400, 0, 32'h500, 14, 10));
        r.push_back(idle(32'h1c0, 0, 32'h1c4, 14, 10));
        r.push_back(mk(32'h180, 1, 32'h104, 1, 32'h600, 0, 32'h108, 0,
                       1, 32'h400, 1, 32'h600, 14, 10));
        r.push_back(idle(32'h104, 1, 32'h600, 15, 11));
        r.push_back(idle(32'h180, 1, 32'h400, 15, 11));
        r.push_back(mk(32'h108, 1, 32'h108, 0, 32'h700, 0, 32'h10c, 0,
                       0, 32'h10c, 0, 32'h10c, 15, 11));
        r.push_back(idle(32'h108, 0, 32'h10c, 16, 11));
        foreach (r[i]) begin
            apply(r[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks += 6;
            if (bp_if.pred_taken !== e.pt) begin
                errors++;
                $display("FAIL same[%0d] pred_taken got %b want %b",
                         i, bp_if.pred_taken, e.pt);
            end
            if (bp_if.pred_target !== e.ptgt) begin
                errors++;
                $display("FAIL same[%0d] pred_target got %h want %h",
                         i, bp_if.pred_target, e.ptgt);
            end
            if (bp_if.mispredict !== e.mp) begin
                errors++;
                $display("FAIL same[%0d] mispredict got %b want %b",
                         i, bp_if.mispredict, e.mp);
            end
            if (bp_if.redirect_pc !== e.rpc) begin
                errors++;
                $display("FAIL same[%0d] redirect_pc got %h want %h",
                         i, bp_if.redirect_pc, e.rpc);
            end
            if (bp_if.branch_count !== e.bc) begin
                errors++;
                $display("FAIL same[%0d] branch_count got %0d want %0d",
                         i, bp_if.branch_count, e.bc);
            end
            if (bp_if.mispred_count !== e.mc) begin
                errors++;
                $display("FAIL same[%0d] mispred_count got %0d want %0d",
                         i, bp_if.mispred_count, e.mc);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        row_t r[$];
        exp_t e;
        r.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, 1,
                       0, 32'h104, 1, 32'h200, 16, 11));
        r.push_back(idle(32'h100, 0, 32'h104, 17, 12));
        r.push_back(idle(32'h180, 0, 32'h184, 17, 12));
        r.push_back(idle(32'h104, 0, 32'h108, 17, 12));
        r.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0,
                       0, 32'h104, 1, 32'h200, 17, 12));
        r.push_back(idle(32'h100, 1, 32'h200, 18, 13));
        foreach (r[i]) begin
            apply(r[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks += 6;
            if (bp_if.pred_taken !== e.pt) begin
                errors++;
                $display("FAIL flush[%0d] pred_taken got %b want %b",
                         i, bp_if.pred_taken, e.pt);
            end
            if (bp_if.pred_target !== e.ptgt) begin
                errors++;
                $display("FAIL flush[%0d] pred_target got %h want %h",
                         i, bp_if.pred_target, e.ptgt);
            end
            if (bp_if.mispredict !== e.mp) begin
                errors++;
                $display("FAIL flush[%0d] mispredict got %b want %b",
                         i, bp_if.mispredict, e.mp);
            end
            if (bp_if.redirect_pc !== e.rpc) begin
                errors++;
                $display("FAIL flush[%0d] redirect_pc got %h want %h",
                         i, bp_if.redirect_pc, e.rpc);
            end
            if (bp_if.branch_count !== e.bc) begin
                errors++;
                $display("FAIL flush[%0d] branch_count got %0d want %0d",
                         i, bp_if.branch_count, e.bc);
            end
            if (bp_if.mispred_count !== e.mc) begin
                errors++;
                $display("FAIL flush[%0d] mispred_count got %0d want %0d",
                         i, bp_if.mispred_count, e.mc);
            end
            if (i < 5) tick();
        end
    endtask

    // Entered right after the final flush-table sample (0x100 hits).
    task automatic test_reset_mid();
        exp_t e;
        #2;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e.pt = 0; e.ptgt = 32'h104; e.mp = 0;
            e.rpc = 32'h4; e.bc = 0; e.mc = 0;
            exp_q.push_back(e);
            if (k == 0) #1;
            else @(negedge clk);
            e = exp_q.pop_front();
            checks += 4;
            if (bp_if.pred_taken !== e.pt) begin
                errors++;
                $display("FAIL rstmid[%0d] pred_taken got %b want %b",
                         k, bp_if.pred_taken, e.pt);
            end
            if (bp_if.pred_target !== e.ptgt) begin
                errors++;
                $display("FAIL rstmid[%0d] pred_target got %h want %h",
                         k, bp_if.pred_target, e.ptgt);
            end
            if (bp_if.branch_count !== e.bc) begin
                errors++;
                $display("FAIL rstmid[%0d] branch_count got %0d want %0d",
                         k, bp_if.branch_count, e.bc);
            end
            if (bp_if.mispred_count !== e.mc) begin
                errors++;
                $display("FAIL rstmid[%0d] mispred_count got %0d want %0d",
                         k, bp_if.mispred_count, e.mc);
            end
            if (k == 0) begin
                tick();
                rst = 1'b0;
            end
        end
        tick();
    endtask

    function automatic void m_look(
        input logic [31:0] pc,
        output logic pt, output logic [31:0] tg
    );
        logic [3:0] ix;
        ix = pc[5:2];
        pt = m_valid[ix] && m_tag[ix] == pc[31:6] && m_ctr[ix][1];
        tg = pt ? m_tgt[ix] : pc + 32'd4;
    endfunction

    task automatic test_random();
        exp_t        e;
        logic [31:0] pc, xpc, xt, ptg, m_bc, m_mc;
        logic        v, t, pt, fl;
        logic [3:0]  ix;
        for (int k = 0; k < 16; k++) begin
            m_valid[k] = 1'b0; m_tag[k] = '0;
            m_tgt[k] = '0; m_ctr[k] = 2'b01;
        end
        m_bc = 0;
        m_mc = 0;
        for (int n = 0; n < 400; n++) begin
            pc  = (32'($urandom_range(0, 3)) << 6) |
                  (32'($urandom_range(0, 15)) << 2);
            xpc = (32'($urandom_range(0, 3)) << 6) |
                  (32'($urandom_range(0, 15)) << 2);
            xt  = 32'($urandom_range(0, 1023)) << 2;
            v   = $urandom_range(0, 3) != 0;
            t   = $urandom_range(0, 1) == 1;
            fl  = $urandom_range(0, 24) == 0;
            m_look(xpc, pt, ptg);
            if ($urandom_range(0, 4) == 0) pt = ~pt;
            drive(pc, v, xpc, t, xt, pt, ptg, fl);
            m_look(pc, e.pt, e.ptgt);
            e.mp  = v && (pt != t || (t && ptg != xt));
            e.rpc = t ? xt : xpc + 32'd4;
            e.bc  = m_bc;
            e.mc  = m_mc;
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            checks += 6;
            if (bp_if.pred_taken !== e.pt) begin
                errors++;
                $display("FAIL rand[%0d] pred_taken got %b want %b",
                         n, bp_if.pred_taken, e.pt);
            end
            if (bp_if.pred_target !== e.ptgt) begin
                errors++;
                $display("FAIL rand[%0d] pred_target got %h want %h",
                         n, bp_if.pred_target, e.ptgt);
            end
            if (bp_if.mispredict !== e.mp) begin
                errors++;
                $display("FAIL rand[%0d] mispredict got %b want %b",
                         n, bp_if.mispredict, e.mp);
            end
            if (bp_if.redirect_pc !== e.rpc) begin
                errors++;
                $display("FAIL rand[%0d] redirect_pc got %h want %h",
                         n, bp_if.redirect_pc, e.rpc);
            end
            if (bp_if.branch_count !== e.bc) begin
                errors++;
                $display("FAIL rand[%0d] branch_count got %0d want %0d",
                         n, bp_if.branch_count, e.bc);
            end
            if (bp_if.mispred_count !== e.mc) begin
                errors++;
                $display("FAIL rand[%0d] mispred_count got %0d want %0d",
                         n, bp_if.mispred_count, e.mc);
            end
            if (v) m_bc++;
            if (e.mp) m_mc++;
            ix = xpc[5:2];
            if (fl) begin
                for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
            end else if (v) begin
                if (m_valid[ix] && m_tag[ix] == xpc[31:6]) begin
                    if (t) begin
                        if (m_ctr[ix] != 2'b11) m_ctr[ix]++;
                        m_tgt[ix] = xt;
                    end else if (m_ctr[ix] != 2'b00) begin
                        m_ctr[ix]--;
                    end
                end else if (t) begin
                    m_valid[ix] = 1'b1;
                    m_tag[ix]   = xpc[31:6];
                    m_tgt[ix]   = xt;
                    m_ctr[ix]   = 2'b10;
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_hysteresis();
        test_same_cycle();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch target buffer (BTB) with 2-bit saturating direction counters for the RV32I pipeline. Every cycle it looks up the current fetch PC and produces the taken prediction and predicted target. The PC-select logic uses these to choose between the sequential PC+4 and the predicted-target source. It also checks each branch or jump resolved in EX against the prediction made for it, updates its table, and drives the mispredict/redirect signals that select the branch or corrected-PC+4 source.

## Interface
- ENTRIES, 16: number of BTB entries; power of two, 2..256; INDEX_W = log2(ENTRIES)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- if_pc  in  32  current fetch PC
- pred_taken  out  1  lookup hit and counter[1]==1
- pred_target  out  32  stored target when pred_taken is 1, otherwise if_pc+4
- ex_valid  in  1  a conditional branch, JAL or JALR resolves in EX this cycle
- ex_pc  in  32  PC of the resolving instruction
- ex_taken  in  1  actual direction
- ex_target  in  32  actual target
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- ex_pred_target  in  32  predicted target carried down the pipe with the instruction
- flush_btb  in  1  synchronous invalidate of all entries
- mispredict  out  1  redirect request to PC select
- redirect_pc  out  32  ex_taken ? ex_target : ex_pc+4
- branch_count  out  32  count of resolved branches
- mispred_count  out  32  count of mispredicts

## Operation
- Entry contents: valid, tag = pc[31:INDEX_W+2], target[31:2], and a 2-bit counter.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Index = pc[INDEX_W+1:2]. pc[1:0] is ignored; targets are word-aligned and pred_target[1:0] = 00.
- Lookup is combinational from the stored table: hit = valid[idx] && tag match.
- mispredict = ex_valid && (ex_pred_taken != ex_taken || (ex_taken && ex_pred_target != ex_target)). It is combinational and is 0 whenever ex_valid is 0.
- Update when ex_valid is 1, applied at the clock edge:
  - Hit: the counter increments when taken and decrements when not taken, saturating at 11 and 00. When taken, the target is overwritten with ex_target.
  - Miss and taken: allocate the entry (valid = 1, tag, target, counter = 10), replacing whatever occupied that index.
  - Miss and not taken: no table change.
- When flush_btb is 1, all valid bits clear at the next edge. Flush takes precedence over a same-cycle update, so no allocation survives it. Counters and targets are left untouched.
- Performance counters:
  - branch_count increments on ex_valid.
  - mispred_count increments on mispredict.
  - Both wrap modulo 2^32 and are not affected by flush_btb.

## Timing
- Lookup has zero latency: pred_taken and pred_target are valid in the same cycle as if_pc.
- An update becomes visible to lookup on the cycle after the edge that writes it.
- When a lookup and an update hit the same index in the same cycle, the lookup returns the pre-update contents.
- mispredict and redirect_pc are combinational, valid in the same cycle as the ex_* inputs.
- Reset (asynchronous; takes effect immediately, including mid-operation):
  - All valid bits 0, all counters 01, targets 0, both performance counters 0.
  - Outputs during and after reset: pred_taken = 0, pred_target = if_pc+4. mispredict and redirect_pc follow the ex_* inputs only.
- There is no handshake and no stall input; the table writes only on ex_valid.

## Structure
- The shared header defines.vh holds:
  - the counter encodings (BP_SNT, BP_WNT, BP_WT, BP_ST) and BP_INIT_CTR = BP_WT;
  - the default ENTRIES value;
  - the existing PCMUX_* select codes, which the control logic drives from pred_taken and mispredict.
- Sub-module btb_table: tag/target/valid/counter storage with one asynchronous read port, one write port, and a bulk valid clear.
- Counter next-state is a local function in branch_predictor. The performance counters stay in the top module.

## Test plan
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104, branch_count=0, mispred_count=0.
- ex_valid, ex_pc=0x100, ex_taken=1, ex_target=0x200, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x200. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x200. Counts are 1/1.
- Aliasing with the 0x100 entry present: if_pc=0x140 (same index 0, different tag) -> pred_taken=0, pred_target=0x144. A taken resolve of 0x140 to 0x300 replaces the entry, and a later lookup of 0x100 misses.
- Hysteresis from counter 10:
  - one not-taken -> 01, prediction not taken;
  - three takens -> 11 (saturated);
  - one not-taken -> 10, prediction still taken with pred_target unchanged.
- Same-cycle update and lookup: update 0x180 taken to 0x400 while if_pc=0x180 -> that cycle pred_taken=0; the next cycle pred_taken=1, pred_target=0x400.
- flush_btb together with a taken allocate of 0x100 -> next cycle miss, branch_count still increments. Assert rst mid-sequence -> pred_taken drops to 0 immediately and both counts read 0.
